core_seq: RTL

- Multi-cycle sequencer for the single-issue RV32 core. It owns the PC and fetches instructions from instruction memory over a valid/ready handshake.
- It latches the instruction for the decoder/imm/ALU path and gates regfile write enable to one writeback cycle. It then advances the PC or takes a jump.
- It halts on ebreak and flags a fetch timeout or a misaligned jump as an error.

---
 rtl/core_seq_pkg.sv | 27 ++
 rtl/core_seq_if.sv | 31 +++
 rtl/core_seq_fetch_wdt.sv | 43 ++++
 rtl/core_seq.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/core_seq_pkg.sv
// +------------------------------------------------------------------+
// | core_seq_pkg: shared state encoding and instruction constants.    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package core_seq_pkg;

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    WAIT  = 3'd1,
    EXEC  = 3'd2,
    WB    = 3'd3,
    HALT  = 3'd4,
    ERR   = 3'd5
  } state_e;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_NOP    = 32'h0000_0013;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

`default_nettype wire

// File: rtl/core_seq_if.sv
// +------------------------------------------------------------------+
// | core_seq_if: instruction-memory request/response bus.            |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

interface core_seq_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/core_seq_fetch_wdt.sv
// +------------------------------------------------------------------+
// | fetch_wdt: 8-bit fetch watchdog, expires at TIMEOUT-1.            |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module fetch_wdt #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 8'd0;
    end else if (en) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == LAST);

endmodule

`default_nettype wire

// File: rtl/core_seq.sv
// +------------------------------------------------------------------+
// | core_seq: multi-cycle fetch/exec/writeback sequencer for RV32.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module core_seq
  import core_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  core_seq_if.master        imem_bus,
  output logic [31:0]       inst,
  output logic [31:0]       pc,
  output logic              exec_en,
  input  logic              regwrite,
  output logic              reg_wen,
  input  logic              jump_en,
  input  logic [31:0]       jump_target,
  output logic              halt,
  output logic              err,
  output logic [31:0]       retire_cnt
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] retire_q, retire_d;
  logic        halt_q, halt_d;
  logic        err_q, err_d;

  logic req_valid;
  logic exec_strobe;
  logic wen_strobe;
  logic wdt_clr;
  logic wdt_en;
  logic wdt_expire;

  fetch_wdt #(
    .TIMEOUT (TIMEOUT)
  ) u_fetch_wdt (
    .clk    (clk),
    .rst    (rst),
    .clr    (wdt_clr),
    .en     (wdt_en),
    .expire (wdt_expire)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    retire_d    = retire_q;
    halt_d      = halt_q;
    err_d       = err_q;
    req_valid   = 1'b0;
    exec_strobe = 1'b0;
    wen_strobe  = 1'b0;
    wdt_clr     = 1'b0;
    wdt_en      = 1'b0;

    case (state_q)
      FETCH: begin
        req_valid = 1'b1;
        if (imem_bus.imem_req_ready) begin
          wdt_clr = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A response arriving on the expiry cycle still wins over the timeout.
        if (imem_bus.imem_rsp_valid) begin
          inst_d  = imem_bus.imem_rdata;
          state_d = EXEC;
        end else if (wdt_expire) begin
          err_d   = 1'b1;
          state_d = ERR;
        end else begin
          wdt_en = 1'b1;
        end
      end
      EXEC: begin
        exec_strobe = 1'b1;
        state_d     = WB;
      end
      WB: begin
        if (inst_q == INST_EBREAK) begin
          halt_d   = 1'b1;
          retire_d = retire_q + 32'd1;
          state_d  = HALT;
        end else if (jump_en && is_misaligned(jump_target)) begin
          err_d   = 1'b1;
          state_d = ERR;
        end else begin
          wen_strobe = regwrite;
          pc_d       = jump_en ? jump_target : pc_q + 32'd4;
          retire_d   = retire_q + 32'd1;
          state_d    = FETCH;
        end
      end
      HALT: state_d = HALT;
      ERR:  state_d = ERR;
      default: state_d = ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      inst_q   <= INST_NOP;
      retire_q <= 32'd0;
      halt_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      retire_q <= retire_d;
      halt_q   <= halt_d;
      err_q    <= err_d;
    end
  end

  // Strobes are masked while reset is held so nothing leaks out mid-reset.
  assign imem_bus.imem_req_valid = rst & req_valid;
  assign imem_bus.imem_addr      = pc_q;
  assign exec_en                 = rst & exec_strobe;
  assign reg_wen                 = rst & wen_strobe;

  assign inst       = inst_q;
  assign pc         = pc_q;
  assign halt       = halt_q;
  assign err        = err_q;
  assign retire_cnt = retire_q;

endmodule

`default_nettype wire
